// File: rtl/drac_pkg.sv
// Shared core types for the drac pipeline: the LSU-to-dcache request record
// plus the default sizing of the dcache request queue.
package drac_pkg;

    typedef enum logic [1:0] {
        MEM_NOP   = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10,
        MEM_AMO   = 2'b11
    } mem_op_t;

    typedef struct packed {
        logic        valid;
        mem_op_t     mem_op;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [39:0] addr;
        logic [63:0] data;
    } req_cpu_dcache_t;

    localparam int DCQ_DEPTH        = 4;
    localparam int DCQ_MAX_INFLIGHT = 8;

endpackage

// File: rtl/dcache_req_queue.sv
// In-order request queue between the LSU and the dcache interface. Requests
// are buffered in a small register FIFO, offered head-first to the dcache,
// and the number of issued-but-unanswered requests is capped.
module dcache_req_queue
    import drac_pkg::*;
#(
    parameter int DEPTH        = DCQ_DEPTH,
    parameter int MAX_INFLIGHT = DCQ_MAX_INFLIGHT
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic                              lsu_valid_i,
    input  req_cpu_dcache_t                   lsu_req_i,
    output logic                              lsu_ready_o,
    output logic                              dc_valid_o,
    output req_cpu_dcache_t                   dc_req_o,
    input  logic                              dc_ready_i,
    input  logic                              dc_rsp_valid_i,
    output logic [$clog2(DEPTH+1)-1:0]        count_o,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int INF_W = $clog2(MAX_INFLIGHT + 1);

    req_cpu_dcache_t  entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             enq;
    logic             deq;
    logic             rsp;

    // Ready depends only on registered occupancy, so the dcache handshake
    // never feeds back combinationally into the LSU.
    assign lsu_ready_o = (count_o != CNT_W'(DEPTH));
    assign dc_valid_o  = (count_o != '0) && (inflight_o != INF_W'(MAX_INFLIGHT)) && !flush_i;
    assign enq         = lsu_valid_i && lsu_ready_o && !flush_i;
    assign deq         = dc_valid_o && dc_ready_i;
    assign rsp         = dc_rsp_valid_i && (inflight_o != '0);

    // Head entry drives the dcache payload; its valid bit mirrors dc_valid_o.
    always_comb begin
        dc_req_o       = entries[rd_ptr];
        dc_req_o.valid = dc_valid_o;
    end

    // Payload storage is written on enqueue only and is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            entries[wr_ptr] <= lsu_req_i;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue at once.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_o <= count_o + CNT_W'(1);
                2'b01:   count_o <= count_o - CNT_W'(1);
                default: count_o <= count_o;
            endcase
        end
    end

    // Outstanding-request counter; survives flush because issued requests
    // still get their responses.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_o <= '0;
        end else begin
            case ({deq, rsp})
                2'b10:   inflight_o <= inflight_o + INF_W'(1);
                2'b01:   inflight_o <= inflight_o - INF_W'(1);
                default: inflight_o <= inflight_o;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_req_queue.sv
// Self-checking bench for dcache_req_queue: a table of per-cycle stimulus
// with hand-derived expectations, plus a payload scoreboard that checks the
// issue order against the acceptance order.
module tb_dcache_req_queue;
    import drac_pkg::*;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            flush_i;
    logic            lsu_valid_i;
    req_cpu_dcache_t lsu_req_i;
    logic            lsu_ready_o;
    logic            dc_valid_o;
    req_cpu_dcache_t dc_req_o;
    logic            dc_ready_i;
    logic            dc_rsp_valid_i;
    logic [2:0]      count_o;
    logic [3:0]      inflight_o;

    typedef struct {
        bit v;
        int rd;
        bit rdy;
        bit rsp;
        bit fl;
        bit e_lrdy;
        bit e_dcv;
        int e_cnt;
        int e_inf;
    } vec_t;

    vec_t            vecs[$];
    req_cpu_dcache_t sb[$];
    int              checks = 0;
    int              passes = 0;

    dcache_req_queue #(.DEPTH(4), .MAX_INFLIGHT(8)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .lsu_valid_i    (lsu_valid_i),
        .lsu_req_i      (lsu_req_i),
        .lsu_ready_o    (lsu_ready_o),
        .dc_valid_o     (dc_valid_o),
        .dc_req_o       (dc_req_o),
        .dc_ready_i     (dc_ready_i),
        .dc_rsp_valid_i (dc_rsp_valid_i),
        .count_o        (count_o),
        .inflight_o     (inflight_o)
    );

    // 10-unit clock period.
    always #5 clk_i = ~clk_i;

    // Builds a recognisable LW request: addr 0x80001000 + rd*8.
    function automatic req_cpu_dcache_t makeReq(int rd);
        req_cpu_dcache_t r;
        r        = '0;
        r.valid  = 1'b1;
        r.mem_op = MEM_LOAD;
        r.funct3 = 3'b010;
        r.rd     = rd[4:0];
        r.addr   = 40'h80001000 + 40'(rd) * 40'd8;
        r.data   = 64'(rd);
        return r;
    endfunction

    task automatic addVec(bit v, int rd, bit rdy, bit rsp, bit fl,
                          bit e_lrdy, bit e_dcv, int e_cnt, int e_inf);
        vec_t x;
        x.v = v; x.rd = rd; x.rdy = rdy; x.rsp = rsp; x.fl = fl;
        x.e_lrdy = e_lrdy; x.e_dcv = e_dcv; x.e_cnt = e_cnt; x.e_inf = e_inf;
        vecs.push_back(x);
    endtask

    task automatic checkOutput(string name, longint actual, longint expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // One clock cycle: drive at negedge, check combinational outputs before the
    // rising edge, check registered state after it, then update the scoreboard.
    task automatic applyStimulus(vec_t t, int idx);
        bit popped;
        @(negedge clk_i);
        lsu_valid_i    = t.v;
        lsu_req_i      = makeReq(t.rd);
        dc_ready_i     = t.rdy;
        dc_rsp_valid_i = t.rsp;
        flush_i        = t.fl;
        #1;
        checkOutput($sformatf("v%0d lsu_ready", idx), longint'(lsu_ready_o), longint'(t.e_lrdy));
        checkOutput($sformatf("v%0d dc_valid", idx), longint'(dc_valid_o), longint'(t.e_dcv));
        checkOutput($sformatf("v%0d req.valid", idx), longint'(dc_req_o.valid), longint'(t.e_dcv));
        popped = 1'b0;
        if (dc_valid_o) begin
            if (sb.size() == 0) begin
                checks++;
                $display("[TB] FAIL v%0d head: dc_valid_o=1 with rd=%0d, expected no request offered",
                         idx, dc_req_o.rd);
            end else begin
                checkOutput($sformatf("v%0d head rd", idx), longint'(dc_req_o.rd), longint'(sb[0].rd));
                checkOutput($sformatf("v%0d head addr", idx), longint'(dc_req_o.addr), longint'(sb[0].addr));
                popped = dc_ready_i;
            end
        end
        @(posedge clk_i);
        #1;
        checkOutput($sformatf("v%0d count", idx), longint'(count_o), longint'(t.e_cnt));
        checkOutput($sformatf("v%0d inflight", idx), longint'(inflight_o), longint'(t.e_inf));
        if (popped) begin
            void'(sb.pop_front());
        end
        if (t.fl) begin
            sb.delete();
        end else if (t.v && t.e_lrdy) begin
            sb.push_back(makeReq(t.rd));
        end
    endtask

    initial begin
        rst_i          = 1'b1;
        flush_i        = 1'b0;
        lsu_valid_i    = 1'b0;
        lsu_req_i      = '0;
        dc_ready_i     = 1'b0;
        dc_rsp_valid_i = 1'b0;

        // Single LW rd=5, offered the cycle after acceptance, then answered.
        addVec(1, 5, 1, 0, 0, 1, 0, 1, 0);
        addVec(0, 0, 1, 0, 0, 1, 1, 0, 1);
        addVec(0, 0, 0, 1, 0, 1, 0, 0, 0);
        // Fill with the dcache stalled; the fifth request is refused.
        addVec(1, 1, 0, 0, 0, 1, 0, 1, 0);
        addVec(1, 2, 0, 0, 0, 1, 1, 2, 0);
        addVec(1, 3, 0, 0, 0, 1, 1, 3, 0);
        addVec(1, 4, 0, 0, 0, 1, 1, 4, 0);
        addVec(1, 5, 0, 0, 0, 0, 1, 4, 0);
        // Full with dc_ready high: still not ready; drain in order 1..4.
        addVec(1, 6, 1, 0, 0, 0, 1, 3, 1);
        addVec(0, 0, 1, 0, 0, 1, 1, 2, 2);
        addVec(0, 0, 1, 0, 0, 1, 1, 1, 3);
        addVec(0, 0, 1, 0, 0, 1, 1, 0, 4);
        addVec(0, 0, 1, 0, 0, 1, 0, 0, 4);
        for (int k = 3; k >= 0; k--) addVec(0, 0, 1, 1, 0, 1, 0, 0, k);
        // Nine issues without responses: the ninth waits for a response.
        addVec(1, 10, 1, 0, 0, 1, 0, 1, 0);
        for (int j = 0; j < 8; j++) addVec(1, 11 + j, 1, 0, 0, 1, 1, 1, j + 1);
        addVec(0, 0, 1, 0, 0, 1, 0, 1, 8);
        addVec(0, 0, 1, 1, 0, 1, 0, 1, 7);
        addVec(0, 0, 1, 0, 0, 1, 1, 0, 8);
        // Flush at count 3 with a request in the same cycle, inflight saturated.
        addVec(1, 20, 0, 0, 0, 1, 0, 1, 8);
        addVec(1, 21, 0, 0, 0, 1, 0, 2, 8);
        addVec(1, 22, 0, 0, 0, 1, 0, 3, 8);
        addVec(1, 23, 1, 0, 1, 1, 0, 0, 8);
        addVec(0, 0, 1, 1, 0, 1, 0, 0, 7);
        addVec(0, 0, 1, 1, 0, 1, 0, 0, 6);
        // Flush at count 3 where an issue would otherwise have been possible.
        addVec(1, 24, 0, 0, 0, 1, 0, 1, 6);
        addVec(1, 25, 0, 0, 0, 1, 1, 2, 6);
        addVec(1, 26, 0, 0, 0, 1, 1, 3, 6);
        addVec(1, 27, 1, 0, 1, 1, 0, 0, 6);
        addVec(0, 0, 1, 0, 0, 1, 0, 0, 6);
        // Count 2: enqueue, issue and response together.
        addVec(1, 30, 0, 0, 0, 1, 0, 1, 6);
        addVec(1, 31, 0, 0, 0, 1, 1, 2, 6);
        addVec(1, 3, 1, 1, 0, 1, 1, 2, 6);
        addVec(0, 0, 1, 0, 0, 1, 1, 1, 7);
        addVec(0, 0, 1, 0, 0, 1, 1, 0, 8);
        for (int k = 7; k >= 0; k--) addVec(0, 0, 1, 1, 0, 1, 0, 0, k);
        // Spurious responses at inflight 0.
        addVec(0, 0, 1, 1, 0, 1, 0, 0, 0);
        addVec(1, 7, 0, 1, 0, 1, 0, 1, 0);
        addVec(0, 0, 1, 0, 0, 1, 1, 0, 1);
        addVec(1, 8, 0, 0, 0, 1, 0, 1, 1);

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checkOutput("reset count", longint'(count_o), 0);
        checkOutput("reset inflight", longint'(inflight_o), 0);
        checkOutput("reset lsu_ready", longint'(lsu_ready_o), 1);
        checkOutput("reset dc_valid", longint'(dc_valid_o), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        // Reset wins over enqueue, issue and response in the same cycle.
        @(negedge clk_i);
        rst_i          = 1'b1;
        lsu_valid_i    = 1'b1;
        lsu_req_i      = makeReq(9);
        dc_ready_i     = 1'b1;
        dc_rsp_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        checkOutput("rstprio count", longint'(count_o), 0);
        checkOutput("rstprio inflight", longint'(inflight_o), 0);
        @(negedge clk_i);
        rst_i          = 1'b0;
        lsu_valid_i    = 1'b0;
        dc_ready_i     = 1'b0;
        dc_rsp_valid_i = 1'b0;
        #1;
        checkOutput("rstprio lsu_ready", longint'(lsu_ready_o), 1);
        checkOutput("rstprio dc_valid", longint'(dc_valid_o), 0);
        sb.delete();

        // Normal operation resumes after reset.
        vecs.delete();
        addVec(1, 9, 0, 0, 0, 1, 0, 1, 0);
        addVec(0, 0, 1, 0, 0, 1, 1, 0, 1);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], 100 + i);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dcache_req_queue.md
DCACHE_REQ_QUEUE -- requirements
Module: dcache_req_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries; power of two, minimum 2.
REQ-002 SHALL have parameter MAX_INFLIGHT, default 8, meaning maximum issued requests awaiting a dcache response.
REQ-003 SHALL have port clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush_i  in  1  discard all queued, not-yet-issued requests.
REQ-006 SHALL have port lsu_valid_i  in  1  LSU request valid.
REQ-007 SHALL have port lsu_req_i  in  req_cpu_dcache_t  LSU request payload (drac_pkg).
REQ-008 SHALL have port lsu_ready_o  out  1  queue can accept a request this cycle.
REQ-009 SHALL have port dc_valid_o  out  1  head request offered to the dcache interface.
REQ-010 SHALL have port dc_req_o  out  req_cpu_dcache_t  head request payload; its valid field equals dc_valid_o.
REQ-011 SHALL have port dc_ready_i  in  1  dcache interface accepts the offered request (already includes same-tag stall).
REQ-012 SHALL have port dc_rsp_valid_i  in  1  one dcache response returned this cycle.
REQ-013 SHALL have port count_o  out  $clog2(DEPTH+1)  queued entries.
REQ-014 SHALL have port inflight_o  out  $clog2(MAX_INFLIGHT+1)  issued requests without response.

Function
REQ-015 SHALL behave as an in-order FIFO: issue order equals acceptance order.
REQ-016 SHALL drive lsu_ready_o = (count_o != DEPTH); no combinational path from dc_ready_i to lsu_ready_o.
REQ-017 SHALL enqueue on lsu_valid_i && lsu_ready_o && !flush_i.
REQ-018 SHALL drive dc_valid_o = (count_o != 0) && (inflight_o != MAX_INFLIGHT) && !flush_i.
REQ-019 SHALL drive dc_req_o from the head entry combinationally; no bypass, so an entry accepted in cycle N is first offered in cycle N+1.
REQ-020 SHALL dequeue (issue) on dc_valid_o && dc_ready_i; dc_req_o SHALL be stable while dc_valid_o is high and dc_ready_i low.
REQ-021 SHALL handle simultaneous enqueue and dequeue with count_o unchanged and both pointers advanced.
REQ-022 SHALL wrap read/write pointers modulo DEPTH.
REQ-023 SHALL update inflight_o as +1 on issue, -1 on dc_rsp_valid_i; simultaneous issue and response leaves it unchanged.
REQ-024 SHALL ignore dc_rsp_valid_i when inflight_o is 0 (no underflow, no issue in that cycle).
REQ-025 SHALL, on flush_i, set count_o and both pointers to 0 in the next cycle; requests presented in the flush cycle are dropped; inflight_o is not affected by flush.
REQ-026 SHALL keep lsu_ready_o low while full even if dc_ready_i is high in the same cycle.

Reset
REQ-027 SHALL, with rst_i high at a rising edge, clear pointers, count_o and inflight_o to 0; hence dc_valid_o = 0, lsu_ready_o = 1.
REQ-028 SHALL take reset priority over flush, enqueue, issue and response in the same cycle; entry payload storage is not reset.

Structure
REQ-029 SHALL reuse req_cpu_dcache_t from drac_pkg; defaults DCQ_DEPTH = 4 and DCQ_MAX_INFLIGHT = 8 SHALL be added to drac_pkg.
REQ-030 SHALL be a single module with no sub-modules; storage is an inline register array.

Verification
REQ-031 SHALL verify: reset, then one LW rd=5 addr 0x80001000 in cycle 1 -> dc_valid_o in cycle 2 with rd=5; dc_ready_i=1 -> count_o 0, inflight_o 1.
REQ-032 SHALL verify: dc_ready_i=0, five back-to-back requests, DEPTH=4 -> first four accepted, lsu_ready_o=0 on fifth, count_o=4; then release -> issue order 1,2,3,4.
REQ-033 SHALL verify: MAX_INFLIGHT=8, nine issues with no responses -> ninth held, dc_valid_o=0, inflight_o=8; one dc_rsp_valid_i -> ninth issues next cycle.
REQ-034 SHALL verify: count_o=3, flush_i high together with lsu_valid_i -> count_o=0 next cycle, nothing issued, inflight_o unchanged.
REQ-035 SHALL verify: count_o=2, simultaneous enqueue, issue and response -> count_o=2, inflight_o unchanged; spurious response at inflight_o=0 -> stays 0.
